ctrl_time_sched: RTL and testbench

CTRL_TIME_SCHED -- requirements
Module: ctrl_time_sched

---
 rtl/ctrl_time_sched_pkg.sv | 18 +
 rtl/ctrl_time_sched_tbl.sv | 74 +++++++
 rtl/ctrl_time_sched.sv | 214 +++++++++++++++++++++
 tb/tb_ctrl_time_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_time_sched_pkg.sv
// Shared constants and types for the time-breakpoint scheduler.
package ctrl_time_sched_pkg;

    // Default number of programmable breakpoint entries (1..DEPTH).
    localparam int DEPTH_DEF       = 15;
    // Width of a breakpoint value (IEEE extended-single payload).
    localparam int EXTENDED_SINGLE = 44;
    // Width of entry indices and entry counts.
    localparam int AW              = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ctrl_time_sched_tbl.sv
// Breakpoint table: DEPTH resettable entries, one write port, two
// combinational read ports (table validation and run-time lookahead).
// Index 0 and indices above DEPTH always read as time 0, value 0.
module ctrl_time_tbl
    import ctrl_time_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TW    = 12
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [TW-1:0]              wtime,
    input  logic [EXTENDED_SINGLE-1:0] wvalue,
    input  logic [AW-1:0]              chk_addr,
    output logic [TW-1:0]              chk_time,
    input  logic [AW-1:0]              run_addr,
    output logic [TW-1:0]              run_time,
    output logic [EXTENDED_SINGLE-1:0] run_value
);

    logic [DEPTH:0][TW-1:0]              time_all;
    logic [DEPTH:0][EXTENDED_SINGLE-1:0] value_all;

    assign time_all[0]  = '0;
    assign value_all[0] = '0;

    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_entry
        logic [TW-1:0]              time_q, time_d;
        logic [EXTENDED_SINGLE-1:0] value_q, value_d;

        // Capture a write addressed to this entry.
        always_comb begin
            time_d  = time_q;
            value_d = value_q;
            if (we && (waddr == AW'(gi))) begin
                time_d  = wtime;
                value_d = wvalue;
            end
        end

        // Entry storage, cleared by reset.
        always_ff @(posedge clk) begin
            if (srst) begin
                time_q  <= '0;
                value_q <= '0;
            end else begin
                time_q  <= time_d;
                value_q <= value_d;
            end
        end

        assign time_all[gi]  = time_q;
        assign value_all[gi] = value_q;
    end

    // Read muxes; unmatched addresses fall back to the fixed zero entry.
    always_comb begin
        chk_time  = '0;
        run_time  = '0;
        run_value = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (chk_addr == AW'(i)) begin
                chk_time = time_all[i];
            end
            if (run_addr == AW'(i)) begin
                run_time  = time_all[i];
                run_value = value_all[i];
            end
        end
    end

endmodule

// File: rtl/ctrl_time_sched.sv
// Time-breakpoint scheduler: validates a programmed table, then steps a
// tick counter through it, presenting the value of the latest breakpoint.
module ctrl_time_sched
    import ctrl_time_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TW    = 12
) (
    input  logic                       clk,
    input  logic                       sta,
    input  logic                       cfg_we,
    input  logic [AW-1:0]              cfg_addr,
    input  logic [TW-1:0]              cfg_time,
    input  logic [EXTENDED_SINGLE-1:0] cfg_value,
    input  logic [AW-1:0]              cfg_num,
    input  logic [TW-1:0]              cfg_period,
    input  logic                       run,
    input  logic                       abort,
    input  logic                       tick,
    output logic [TW-1:0]              counter,
    output logic [AW-1:0]              idx,
    output logic [EXTENDED_SINGLE-1:0] y,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_e                     state_q, state_d;
    logic [AW-1:0]              num_q, num_d;
    logic [TW-1:0]              period_q, period_d;
    logic [AW-1:0]              chk_k_q, chk_k_d;
    logic [TW-1:0]              prev_q, prev_d;
    logic                       err_acc_q, err_acc_d;
    logic [TW-1:0]              counter_q, counter_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic [EXTENDED_SINGLE-1:0] y_q, y_d;
    logic                       cfg_err_q, cfg_err_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       tbl_we;
    logic [TW-1:0]              chk_time;
    logic [TW-1:0]              run_time;
    logic [EXTENDED_SINGLE-1:0] run_value;
    logic                       idle_like;
    logic                       chk_last;
    logic                       chk_fail;
    logic                       at_end;
    logic                       advance;
    logic [TW-1:0]              period_m1;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign tbl_we    = cfg_we && idle_like;
    assign period_m1 = period_q - TW'(1);

    ctrl_time_tbl #(
        .DEPTH (DEPTH),
        .TW    (TW)
    ) u_tbl (
        .clk       (clk),
        .srst      (sta),
        .we        (tbl_we),
        .waddr     (cfg_addr),
        .wtime     (cfg_time),
        .wvalue    (cfg_value),
        .chk_addr  (chk_k_q),
        .chk_time  (chk_time),
        .run_addr  (AW'(idx_q + AW'(1))),
        .run_time  (run_time),
        .run_value (run_value)
    );

    // With num = 0 the single check cycle only validates the period.
    assign chk_last = (chk_k_q >= num_q);
    assign chk_fail = (period_q == '0) ||
                      ((num_q != '0) && ((chk_time <= prev_q) || (chk_time > period_m1)));
    assign at_end   = (counter_q == period_m1);
    assign advance  = (idx_q < num_q) && (TW'(counter_q + TW'(1)) == run_time);

    // State register.
    always_ff @(posedge clk) begin
        if (sta) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; abort outranks run and tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (run) state_d = ST_CHECK;
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (chk_last) begin
                    state_d = (err_acc_q || chk_fail) ? ST_IDLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && at_end) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags registered from the upcoming state.
    always_comb begin
        busy_d = (state_d == ST_CHECK) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Datapath: run setup, table validation scan and run-time stepping.
    always_comb begin
        num_d     = num_q;
        period_d  = period_q;
        chk_k_d   = chk_k_q;
        prev_d    = prev_q;
        err_acc_d = err_acc_q;
        counter_d = counter_q;
        idx_d     = idx_q;
        y_d       = y_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run) begin
                    num_d     = (cfg_num > DEPTH_W) ? DEPTH_W : cfg_num;
                    period_d  = cfg_period;
                    cfg_err_d = 1'b0;
                    chk_k_d   = AW'(1);
                    prev_d    = '0;
                    err_acc_d = 1'b0;
                    counter_d = '0;
                    idx_d     = '0;
                    y_d       = '0;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    counter_d = '0;
                    idx_d     = '0;
                    y_d       = '0;
                end else begin
                    chk_k_d   = AW'(chk_k_q + AW'(1));
                    prev_d    = chk_time;
                    err_acc_d = err_acc_q || chk_fail;
                    if (chk_last && (err_acc_q || chk_fail)) begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    counter_d = '0;
                    idx_d     = '0;
                    y_d       = '0;
                end else if (tick) begin
                    if (!at_end) begin
                        counter_d = TW'(counter_q + TW'(1));
                    end
                    if (advance) begin
                        idx_d = AW'(idx_q + AW'(1));
                        y_d   = run_value;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (sta) begin
            num_q     <= '0;
            period_q  <= '0;
            chk_k_q   <= '0;
            prev_q    <= '0;
            err_acc_q <= 1'b0;
            counter_q <= '0;
            idx_q     <= '0;
            y_q       <= '0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            num_q     <= num_d;
            period_q  <= period_d;
            chk_k_q   <= chk_k_d;
            prev_q    <= prev_d;
            err_acc_q <= err_acc_d;
            counter_q <= counter_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            cfg_err_q <= cfg_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign counter = counter_q;
    assign idx     = idx_q;
    assign y       = y_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ctrl_time_sched.sv
// Randomized self-checking bench for ctrl_time_sched against a
// transaction-level model of the breakpoint table and run rules.
module tb_ctrl_time_sched;

    localparam int DEPTH = 15;
    localparam int TW    = 12;
    localparam int VW    = 44;

    logic          clk = 1'b0;
    logic          sta = 1'b1;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [TW-1:0] cfg_time = '0;
    logic [VW-1:0] cfg_value = '0;
    logic [3:0]    cfg_num = '0;
    logic [TW-1:0] cfg_period = '0;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic          tick = 1'b0;
    logic [TW-1:0] counter;
    logic [3:0]    idx;
    logic [VW-1:0] y;
    logic          busy, done, cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Model of the programmed table (entry 0 is implicitly time 0, value 0).
    int            mt [1:DEPTH];
    logic [VW-1:0] mv [1:DEPTH];

    ctrl_time_sched #(.DEPTH(DEPTH), .TW(TW)) dut (
        .clk        (clk),
        .sta        (sta),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_time   (cfg_time),
        .cfg_value  (cfg_value),
        .cfg_num    (cfg_num),
        .cfg_period (cfg_period),
        .run        (run),
        .abort      (abort),
        .tick       (tick),
        .counter    (counter),
        .idx        (idx),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 1; k <= DEPTH; k++) begin
            mt[k] = 0;
            mv[k] = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_counter"}, 64'(counter), 64'd0);
        check({tag, "_idx"},     64'(idx),     64'd0);
        check({tag, "_y"},       64'(y),       64'd0);
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_done"},    64'(done),    64'd0);
    endtask

    // Table write issued while the scheduler is idle or done.
    task automatic wr(input int a, input int t, input logic [VW-1:0] v);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_time = TW'(t); cfg_value = v;
        step();
        cfg_we = 1'b0;
        if (a >= 1 && a <= DEPTH) begin
            mt[a] = t;
            mv[a] = v;
        end
    endtask

    // Expected y/idx at a given run time: latest breakpoint at or before c.
    task automatic expect_at(input int c, input int n, output logic [VW-1:0] ey, output int ei);
        ey = '0;
        ei = 0;
        for (int k = 1; k <= n; k++) begin
            if (mt[k] <= c) begin
                ey = mv[k];
                ei = k;
            end
        end
    endtask

    // One run transaction. tdiv: 0 = random ticks, else tick every tdiv-th cycle.
    // abort_at / sta_at: run counter value at which to abort / reset (-1 = never).
    task automatic do_run(input int n_in, input int per, input int tdiv,
                          input int abort_at, input int sta_at, input bit wr_in_run);
        int            n, lat, ticks, ec, ei, prev;
        bit            valid, t;
        logic [VW-1:0] ey;
        n = (n_in > DEPTH) ? DEPTH : n_in;
        valid = (per != 0);
        prev = 0;
        for (int k = 1; k <= n; k++) begin
            if (mt[k] <= prev || mt[k] > per - 1) valid = 1'b0;
            prev = mt[k];
        end
        $display("run num=%0d period=%0d tdiv=%0d abort_at=%0d sta_at=%0d expect_valid=%0d",
                 n_in, per, tdiv, abort_at, sta_at, valid);
        cfg_num = 4'(n_in); cfg_period = TW'(per); run = 1'b1;
        step();
        run = 1'b0;
        lat = (n > 0) ? n : 1;
        for (int i = 0; i < lat; i++) begin
            check("chk_busy", 64'(busy), 64'd1);
            check("chk_y", 64'(y), 64'd0);
            step();
        end
        if (!valid) begin
            check("err_flag", 64'(cfg_err), 64'd1);
            check_zero("err");
            return;
        end
        check("pass_err", 64'(cfg_err), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        check("start_cnt", 64'(counter), 64'd0);
        check("start_y", 64'(y), 64'd0);
        ticks = 0;
        for (int cyc = 0; cyc < 4000 && ticks < per; cyc++) begin
            t = (tdiv == 0) ? 1'($urandom % 2) : ((cyc % tdiv) == (tdiv - 1));
            tick = t;
            if (ticks == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0; tick = 1'b0;
                check_zero("abort");
                return;
            end
            if (ticks == sta_at) begin
                sta = 1'b1;
                step();
                sta = 1'b0; tick = 1'b0;
                model_clear();
                check_zero("sta");
                check("sta_err", 64'(cfg_err), 64'd0);
                return;
            end
            if (wr_in_run && cyc == 0) begin
                cfg_we = 1'b1; cfg_addr = 4'd2; cfg_time = TW'(7); cfg_value = 44'h777;
            end
            run = ($urandom % 8) == 0;
            step();
            tick = 1'b0; run = 1'b0; cfg_we = 1'b0;
            if (t) ticks++;
            ec = (ticks < per) ? ticks : per - 1;
            expect_at(ec, n, ey, ei);
            check("run_cnt",  64'(counter), 64'(ec));
            check("run_y",    64'(y),       64'(ey));
            check("run_idx",  64'(idx),     64'(ei));
            check("run_done", 64'(done),    64'(ticks >= per));
            check("run_busy", 64'(busy),    64'(ticks < per));
        end
        check("run_timeout", 64'(ticks >= per), 64'd1);
        // Final values must hold in DONE regardless of further ticks.
        expect_at(per - 1, n, ey, ei);
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            check("hold_cnt",  64'(counter), 64'(per - 1));
            check("hold_y",    64'(y),       64'(ey));
            check("hold_done", 64'(done),    64'd1);
        end
    endtask

    task automatic load_abc();
        wr(1, 3, 44'hA);
        wr(2, 5, 44'hB);
        wr(3, 9, 44'hC);
    endtask

    initial begin
        model_clear();
        step();
        step();
        check_zero("reset");
        check("reset_err", 64'(cfg_err), 64'd0);
        sta = 1'b0;
        step();

        load_abc();
        do_run(3, 12, 1, -1, -1, 1'b0);
        check("abc_final_idx", 64'(idx), 64'd3);
        do_run(3, 12, 3, -1, -1, 1'b0);

        wr(1, 5, 44'h1); wr(2, 5, 44'h2);
        do_run(2, 12, 1, -1, -1, 1'b0);
        wr(1, 4, 44'h1); wr(2, 12, 44'h2);
        do_run(2, 12, 1, -1, -1, 1'b0);

        do_run(0, 4, 1, -1, -1, 1'b0);

        load_abc();
        do_run(3, 12, 1, 6, -1, 1'b1);
        do_run(3, 12, 1, -1, -1, 1'b0);

        do_run(3, 12, 2, -1, 5, 1'b0);
        do_run(1, 12, 1, -1, -1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int tacc, per, n, ab;
            tacc = 0;
            for (int k = 1; k <= DEPTH; k++) begin
                if ($urandom % 4 != 0) tacc += $urandom_range(1, 4);
                else tacc = $urandom_range(0, 40);
                wr(k, tacc, {$urandom, $urandom});
            end
            wr(0, $urandom_range(0, 40), {$urandom, $urandom});
            per = $urandom_range(0, 60);
            n   = $urandom_range(0, 15);
            ab  = ($urandom % 5 == 0) ? $urandom_range(0, 30) : -1;
            do_run(n, per, $urandom_range(0, 3), ab, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
